icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_if.sv | 35 +++
 rtl/icache_data_array.sv | 54 +++++
 rtl/icache.sv | 132 +++++++++++++
 tb/tb_icache.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared geometry constants and state encoding for the instruction cache
//
// Purpose: default line count, block size and the field widths derived from
//          them, plus the controller state encoding. Every icache file imports
//          this package.
// Ports:   none (package).
package icache_pkg;

  localparam int ICACHE_LINES     = 16;
  localparam int ICACHE_BLK_BYTES = 32;
  localparam int ICACHE_BLK_WID   = ICACHE_BLK_BYTES * 8;
  localparam int ICACHE_OFF_WID   = $clog2(ICACHE_BLK_BYTES);
  localparam int ICACHE_IDX_WID   = $clog2(ICACHE_LINES);
  localparam int ICACHE_TAG_WID   = 32 - ICACHE_OFF_WID - ICACHE_IDX_WID;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side handshake bundle of the instruction cache
//
// Purpose: groups the IF-stage request/response and the block-fill signals.
// Ports:   if_req, if_pc              fetch request from the IF stage
//          if_valid, if_inst          one-cycle instruction return
//          mem_req, mem_addr          block fetch request to the memory controller
//          mem_done, mem_data         block fill complete pulse and block data
// Modports: slave  - the cache (receives fetches, issues fills)
//           master - the environment (IF stage plus memory controller)
interface icache_if
  import icache_pkg::*;
#(
  parameter int BLK_BYTES = ICACHE_BLK_BYTES
) ();

  logic                   if_req;
  logic [31:0]            if_pc;
  logic                   if_valid;
  logic [31:0]            if_inst;
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_done;
  logic [BLK_BYTES*8-1:0] mem_data;

  modport slave (
    input  if_req, if_pc, mem_done, mem_data,
    output if_valid, if_inst, mem_req, mem_addr
  );

  modport master (
    output if_req, if_pc, mem_done, mem_data,
    input  if_valid, if_inst, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - direct-mapped data, tag and valid storage
//
// Purpose: one block of data, one tag and one valid bit per line.
//          Asynchronous read, synchronous write; clear-all wipes every valid bit.
// Ports:   clk, rst                   clock, synchronous active-high reset (valid bits only)
//          rd_idx -> rd_valid, rd_tag, rd_data   combinational lookup
//          wr_en, wr_idx, wr_tag, wr_data        line fill (also sets valid)
//          clr_all                    clear every valid bit; wins over wr_en
module icache_data_array
  import icache_pkg::*;
#(
  parameter int LINES     = ICACHE_LINES,
  parameter int BLK_BYTES = ICACHE_BLK_BYTES,
  parameter int IDX_W     = $clog2(LINES),
  parameter int TAG_W     = 32 - $clog2(BLK_BYTES) - $clog2(LINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_valid,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [BLK_BYTES*8-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic [BLK_BYTES*8-1:0] wr_data,
  input  logic                   clr_all
);

  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tags [LINES];
  logic [BLK_BYTES*8-1:0] data [LINES];

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data carry no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped blocking instruction cache
//
// Purpose: serves IF-stage fetches from a direct-mapped array; a miss issues
//          one block fill to the memory controller and returns the word from
//          the fill data. Optional macro ICACHE_FLUSH_EN adds a flush input
//          that invalidates every line in one cycle.
// Ports:   clk       clock
//          rst       synchronous active-high reset
//          rdy       global ready; low freezes every register
//          flush     (ICACHE_FLUSH_EN only) invalidate all lines
//          bus       icache_if.slave: if_req/if_pc in, if_valid/if_inst out,
//                    mem_req/mem_addr out, mem_done/mem_data in
module icache
  import icache_pkg::*;
#(
  parameter int LINES     = ICACHE_LINES,
  parameter int BLK_BYTES = ICACHE_BLK_BYTES
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
`ifdef ICACHE_FLUSH_EN
  input  logic    flush,
`endif
  icache_if.slave bus
);

  localparam int OFF_W  = $clog2(BLK_BYTES);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WSEL_W = OFF_W - 2;

  icache_state_e          state;
  logic [31:2]            pc_q;      // fetch address of the outstanding miss
  logic                   flushed;   // a flush landed while this fill was in flight
  logic                   flush_i;

  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [BLK_BYTES*8-1:0] rd_data;
  logic                   hit;
  logic                   start;
  logic                   wr_en;
  logic                   clr_all;
  logic [31:0]            hit_word;
  logic [31:0]            fill_word;
  logic [WSEL_W-1:0]      pc_word;
  logic [WSEL_W-1:0]      fill_wsel;
  logic                   unused_pc_bits;

`ifdef ICACHE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Byte lane within a word is irrelevant: fetches are word aligned.
  assign unused_pc_bits = ^bus.if_pc[1:0];

  assign pc_word   = bus.if_pc[2 +: WSEL_W];
  assign fill_wsel = pc_q[2 +: WSEL_W];
  assign hit       = rd_valid && (rd_tag == bus.if_pc[31 -: TAG_W]);
  assign hit_word  = rd_data[{pc_word, 5'd0} +: 32];
  assign fill_word = bus.mem_data[{fill_wsel, 5'd0} +: 32];

  // The cycle carrying if_valid is the tail of the previous request, so the
  // still-high if_req is not sampled again; a flush also defers the lookup.
  assign start   = (state == S_IDLE) && bus.if_req && !bus.if_valid && !flush_i;
  assign wr_en   = rdy && !rst && (state == S_WAIT) && bus.mem_done && !flushed && !flush_i;
  assign clr_all = rdy && flush_i;

  icache_data_array #(
    .LINES     (LINES),
    .BLK_BYTES (BLK_BYTES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.if_pc[OFF_W +: IDX_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (pc_q[OFF_W +: IDX_W]),
    .wr_tag   (pc_q[31 -: TAG_W]),
    .wr_data  (bus.mem_data),
    .clr_all  (clr_all)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc_q         <= '0;
      flushed      <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      bus.if_valid <= 1'b0;
      bus.if_inst  <= '0;
    end else if (rdy) begin
      bus.if_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (hit) begin
              bus.if_valid <= 1'b1;
              bus.if_inst  <= hit_word;
            end else begin
              pc_q         <= bus.if_pc[31:2];
              bus.mem_addr <= {bus.if_pc[31:OFF_W], {OFF_W{1'b0}}};
              bus.mem_req  <= 1'b1;
              state        <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            flushed <= 1'b1;
          end
          if (bus.mem_done) begin
            bus.mem_req  <= 1'b0;
            bus.if_valid <= 1'b1;
            bus.if_inst  <= fill_word;
            flushed      <= 1'b0;
            state        <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache against a block-address reference model
module tb_icache;
  import icache_pkg::*;

  localparam int LINES     = 16;
  localparam int BLK_BYTES = 32;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
`ifdef ICACHE_FLUSH_EN
  logic flush;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which block address (pc / BLK_BYTES) each line holds.
  bit          m_valid [LINES];
  int unsigned m_blk   [LINES];

  always #5 clk = ~clk;

  icache_if #(.BLK_BYTES(BLK_BYTES)) bus ();

  icache #(
    .LINES     (LINES),
    .BLK_BYTES (BLK_BYTES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
`ifdef ICACHE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  // Backing memory contents: every byte is the XOR of its address bytes,
  // so block 0 holds byte k = k.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [BLK_BYTES*8-1:0] block_data(input logic [31:0] base);
    logic [BLK_BYTES*8-1:0] d;
    for (int k = 0; k < BLK_BYTES; k++) d[8*k +: 8] = mem_byte(base + k);
    return d;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
  endfunction

  task automatic m_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete fetch, entered and left at a negedge. The model alone decides
  // hit or miss; if_req is held through the if_valid cycle to show it is not
  // re-sampled there.
  task automatic fetch(input logic [31:0] pc, input int waits, input int freeze, input bit flush_mid);
    int unsigned blk;
    int          idx;
    bit          hit;
    bit          keep;
    logic [31:0] base;
    blk  = pc / BLK_BYTES;
    idx  = blk % LINES;
    hit  = m_valid[idx] && (m_blk[idx] == blk);
    base = blk * BLK_BYTES;
    keep = 1'b1;
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    @(negedge clk);
    if (hit) begin
      check("hit_valid", {31'd0, bus.if_valid}, 32'd1);
      check("hit_inst", bus.if_inst, exp_inst(pc));
      check("hit_mem_req", {31'd0, bus.mem_req}, 32'd0);
    end else begin
      check("miss_req", {31'd0, bus.mem_req}, 32'd1);
      check("miss_addr", bus.mem_addr, base);
      check("miss_no_valid", {31'd0, bus.if_valid}, 32'd0);
      for (int w = 0; w < waits; w++) begin
        @(negedge clk);
        check("wait_req", {31'd0, bus.mem_req}, 32'd1);
        check("wait_addr", bus.mem_addr, base);
      end
      if (freeze > 0) begin
        rdy = 1'b0;
        for (int f = 0; f < freeze; f++) begin
          @(negedge clk);
          check("frz_req", {31'd0, bus.mem_req}, 32'd1);
          check("frz_addr", bus.mem_addr, base);
          check("frz_valid", {31'd0, bus.if_valid}, 32'd0);
        end
        rdy = 1'b1;
      end
      if (flush_mid) begin
`ifdef ICACHE_FLUSH_EN
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_clear();
        keep = 1'b0;
        check("flush_wait_req", {31'd0, bus.mem_req}, 32'd1);
`endif
      end
      bus.mem_done = 1'b1;
      bus.mem_data = block_data(base);
      @(negedge clk);
      bus.mem_done = 1'b0;
      bus.mem_data = {BLK_BYTES{8'hEE}};
      check("fill_valid", {31'd0, bus.if_valid}, 32'd1);
      check("fill_inst", bus.if_inst, exp_inst(pc));
      check("fill_req_drop", {31'd0, bus.mem_req}, 32'd0);
      if (keep) begin
        m_valid[idx] = 1'b1;
        m_blk[idx]   = blk;
      end
    end
    @(negedge clk);
    check("pulse_end", {31'd0, bus.if_valid}, 32'd0);
    check("no_resample", {31'd0, bus.mem_req}, 32'd0);
    bus.if_req = 1'b0;
    bus.if_pc  = $urandom;
  endtask

  initial begin
    logic [31:0] pc;
    rst          = 1'b1;
    rdy          = 1'b1;
`ifdef ICACHE_FLUSH_EN
    flush        = 1'b0;
`endif
    bus.if_req   = 1'b0;
    bus.if_pc    = 32'h0;
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    m_clear();
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_if_inst", bus.if_inst, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, same-line hit, conflicting tag evicts, original misses again.
    fetch(32'h0000_0000, 1, 0, 1'b0);
    check("first_inst_const", bus.if_inst, 32'h0302_0100);
    fetch(32'h0000_001C, 0, 0, 1'b0);
    check("hit_inst_const", bus.if_inst, 32'h1F1E_1D1C);
    fetch(32'h0000_0200, 2, 0, 1'b0);
    fetch(32'h0000_0000, 0, 0, 1'b0);

    // Freeze for five cycles while the fill is outstanding.
    fetch(32'h0000_0404, 1, 5, 1'b0);
    fetch(32'h0000_0408, 0, 0, 1'b0);

    // Reset while waiting for a fill abandons it and empties the cache.
    bus.if_req = 1'b1;
    bus.if_pc  = 32'h0000_0600;
    @(negedge clk);
    check("rstw_req_set", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    bus.if_req = 1'b0;
    m_clear();
    check("rstw_req", {31'd0, bus.mem_req}, 32'd0);
    check("rstw_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rstw_addr", bus.mem_addr, 32'd0);
    fetch(32'h0000_0000, 0, 0, 1'b0);

    // Spurious fill completion in IDLE must leave outputs and lines alone.
    bus.mem_done = 1'b1;
    bus.mem_data = {BLK_BYTES{8'h5A}};
    @(negedge clk);
    bus.mem_done = 1'b0;
    check("spur_valid", {31'd0, bus.if_valid}, 32'd0);
    check("spur_req", {31'd0, bus.mem_req}, 32'd0);
    fetch(32'h0000_001C, 0, 0, 1'b0);

`ifdef ICACHE_FLUSH_EN
    // Idle flush invalidates a filled line.
    fetch(32'h0000_0040, 0, 0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_clear();
    fetch(32'h0000_0040, 0, 0, 1'b0);
    // Flush beats a same-cycle request; the request then misses.
    bus.if_req = 1'b1;
    bus.if_pc  = 32'h0000_0040;
    flush      = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_clear();
    check("fprio_valid", {31'd0, bus.if_valid}, 32'd0);
    check("fprio_req", {31'd0, bus.mem_req}, 32'd0);
    fetch(32'h0000_0040, 0, 0, 1'b0);
    // Flush during a fill: instruction returned, line left invalid.
    fetch(32'h0000_0080, 1, 0, 1'b1);
    fetch(32'h0000_0084, 0, 0, 1'b0);
`endif

    // Random fetches over four tags so hits and evictions both occur.
    for (int n = 0; n < 60; n++) begin
      pc = {21'd0, 2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 2'($urandom)};
      fetch(pc, $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 2 : 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
